decoupled_vr_rx_fifo: RTL and testbench
=======================================

// Module: decoupled_vr_rx_fifo
// PURPOSE
//  Receiving (slave) end of the decoupled ready/valid interface, with buffering behind it.
//  Accepts beats from a ready/valid master and stores them in a Depth-entry FIFO.
//  Exposes them to local logic through a first-word-fall-through pop port.
//  Sits at tile/cohort ingress wherever a ready/valid producer feeds a block that pops at its own pace.
// PARAMETERS
//  DataWidth  fifo_ctrl_pkg::data_width  beat width in bits
//  Depth      fifo_ctrl_pkg::fifo_depth (4)  entries; power of two, >= 2
// PORTS
//  clk        in   1                      single clock, all state on rising edge
//  rst_n      in   1                      asynchronous, active-low reset
//  in_valid   in   1                      slave side: master presents a beat
//  in_ready   out  1                      slave side: FIFO can accept a beat (registered)
//  in_data    in   DataWidth              slave side: beat payload
//  pop        in   1                      consumer removes the head entry this cycle
//  rd_data    out  DataWidth              head entry (FWFT); valid only when !empty
//  empty      out  1                      no entries held
//  count      out  $clog2(Depth+1)        entries currently held
//  proto_err  out  1                      sticky ready/valid protocol violation (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: in_ready=0, empty=1, count=0, proto_err=0, wr_ptr=rd_ptr=0.
//    rd_data is don't-care while empty.
//  push = in_valid & in_ready;  do_pop = pop & !empty.  pop while empty is ignored; no state change.
//  in_ready is a flop: next = (count_next != Depth).
//    First cycle after reset release it rises to 1.
//    No combinational path from in_valid or pop to in_ready.
//  count_next = count + push - do_pop.  Simultaneous push and do_pop leave count unchanged.
//  Full (count==Depth): in_ready=0 that cycle, so a same-cycle pop frees a slot only for the next cycle.
//  Empty: push lands at wr_ptr. rd_data/empty update one cycle after the push (latency 1, no bypass).
//    A pop in the push cycle is ignored.
//  Pointers are log2(Depth) bits and wrap naturally Depth-1 -> 0.
//    Full/empty are decided from count, never from pointer compare.
//  Ordering: strict FIFO; no beat is dropped or duplicated.
//  Reset asserted mid-operation: all contents discarded, in_ready drops immediately (async).
//    Storage array itself is not reset.
// CONFIGURATION
//  Macro DECOUPLED_VR_RX_PROTO_CHECK_EN.
//  Defined: a checker registers last_stall = in_valid & !in_ready and last_data = in_data.
//    proto_err is set, and held until reset, if last_stall and this cycle shows either:
//      - in_valid == 0 (valid withdrawn before accept), or
//      - in_data != last_data (data changed while stalled).
//  Undefined: checker logic absent; proto_err tied 0.
//  FIFO datapath identical in both builds.
// STRUCTURE
//  fifo_ctrl_pkg: data_width, fifo_depth; typedef cnt_t = logic [$clog2(fifo_depth+1)-1:0];
//    typedef ptr_t = logic [$clog2(fifo_depth)-1:0].
//  One sub-module, decoupled_vr_rx_fifo_mem: Depth x DataWidth register array.
//    1 write port (we, waddr, wdata), 1 async read port (raddr -> rdata); no reset.
//  Top holds pointers, count, in_ready flop and the optional checker.
// TESTING
//  1. Reset, then idle 2 cycles -> in_ready 0 in reset, 1 on 1st cycle after release;
//     empty=1, count=0.
//  2. Depth=4: push 0xA1..0xA4 back-to-back, no pop -> count=4, in_ready=0 the cycle after the 4th push;
//     a 5th valid beat 0xA5 is held off.
//  3. From full, pop once with 0xA5 still valid -> rd_data=0xA1 before pop;
//     in_ready=1 next cycle; 0xA5 accepted one cycle later; count back to 4.
//  4. Steady stream: push and pop every cycle for 20 beats (incrementing data)
//     -> count constant, output order exact, pointers wrap 3->0 without loss.
//  5. pop held high while empty for 3 cycles, then push 0x5A
//     -> no underflow, count never negative; 0x5A appears at rd_data 1 cycle later.
//  6. With DECOUPLED_VR_RX_PROTO_CHECK_EN: stall beat 0x11, change data to 0x12 next cycle
//     -> proto_err=1 next edge and stays 1 until rst_n; without macro proto_err stays 0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared widths and index types for the decoupled ready/valid receive FIFO.
package fifo_ctrl_pkg;

    localparam int unsigned data_width = 8;
    localparam int unsigned fifo_depth = 4;

    localparam int unsigned cnt_w = $clog2(fifo_depth + 1);
    localparam int unsigned ptr_w = $clog2(fifo_depth);

    typedef logic [cnt_w-1:0] cnt_t;
    typedef logic [ptr_w-1:0] ptr_t;

endpackage

// File: rtl/decoupled_vr_rx_fifo_mem.sv
// Depth x DataWidth register array: one write port, one asynchronous read port, no reset.
module decoupled_vr_rx_fifo_mem
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = data_width,
    parameter int unsigned Depth     = fifo_depth
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Depth)-1:0] waddr,
    input  logic [DataWidth-1:0]     wdata,
    input  logic [$clog2(Depth)-1:0] raddr,
    output logic [DataWidth-1:0]     rdata
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents are deliberately not reset; validity is tracked by the controller.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/decoupled_vr_rx_fifo.sv
// Ready/valid slave feeding a first-word-fall-through FIFO with a local pop port.
// Optional protocol checker enabled by defining DECOUPLED_VR_RX_PROTO_CHECK_EN.
module decoupled_vr_rx_fifo
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = data_width,
    parameter int unsigned Depth     = fifo_depth
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DataWidth-1:0]       in_data,
    input  logic                       pop,
    output logic [DataWidth-1:0]       rd_data,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       proto_err
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            empty_q, empty_d;
    logic            push_c;
    logic            do_pop_c;

    // Occupancy is the single source of truth for full/empty; pointers just wrap.
    always_comb begin
        push_c     = in_valid & in_ready_q;
        do_pop_c   = pop & ~empty_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d    = count_q + CntW'(push_c) - CntW'(do_pop_c);
        empty_d    = (count_d == '0);
        in_ready_d = (count_d != CntW'(Depth));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            empty_q    <= empty_d;
        end
    end

    decoupled_vr_rx_fifo_mem #(
        .DataWidth(DataWidth),
        .Depth    (Depth)
    ) u_mem (
        .clk  (clk),
        .we   (push_c),
        .waddr(wr_ptr_q),
        .wdata(in_data),
        .raddr(rd_ptr_q),
        .rdata(rd_data)
    );

    assign in_ready = in_ready_q;
    assign empty    = empty_q;
    assign count    = count_q;

`ifdef DECOUPLED_VR_RX_PROTO_CHECK_EN
    logic                 last_stall_q, last_stall_d;
    logic [DataWidth-1:0] last_data_q, last_data_d;
    logic                 proto_err_q, proto_err_d;

    // A stalled beat must stay valid with unchanged data until it is accepted.
    always_comb begin
        last_stall_d = in_valid & ~in_ready_q;
        last_data_d  = in_data;
        proto_err_d  = proto_err_q;
        if (last_stall_q && (!in_valid || (in_data != last_data_q))) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_stall_q <= 1'b0;
            last_data_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            last_stall_q <= last_stall_d;
            last_data_q  <= last_data_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_decoupled_vr_rx_fifo.sv
// Randomized and directed bench for decoupled_vr_rx_fifo against a queue-based model.
module tb_decoupled_vr_rx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
`ifdef DECOUPLED_VR_RX_PROTO_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          pop      = 1'b0;
    logic          in_ready;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [2:0]    count;
    logic          proto_err;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    logic [DW-1:0] mq[$];
    bit            m_ready      = 1'b0;
    bit            m_perr       = 1'b0;
    bit            m_last_stall = 1'b0;
    logic [DW-1:0] m_last_data  = '0;

    decoupled_vr_rx_fifo #(
        .DataWidth(DW),
        .Depth    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .pop      (pop),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Model: queue semantics straight from the accept/pop rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ready      = 1'b0;
            m_perr       = 1'b0;
            m_last_stall = 1'b0;
            m_last_data  = '0;
        end else begin
            bit acc, tak;
            acc = in_valid && m_ready;
            tak = pop && (mq.size() > 0);
            if (PCHK && m_last_stall && (!in_valid || in_data != m_last_data)) m_perr = 1'b1;
            m_last_stall = in_valid && !m_ready;
            m_last_data  = in_data;
            if (tak) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            m_ready = (mq.size() != DEPTH);
        end
    end

    // Single compare process, sampled on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            if (mq.size() > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
            chk("proto_err", 32'(proto_err), 32'(m_perr));
        end
    end

    initial begin
        logic [DW-1:0] exp_order [4];
        bit stalled;

        // 1: reset and idle
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (2) cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_count", 32'(count), 32'd0);

        // 2: fill to full, 5th beat held off
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'hA1 + i);
            cyc();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_data = 8'hA5;
        cyc();
        chk("held_count", 32'(count), 32'd4);
        chk("held_in_ready", 32'(in_ready), 32'd0);

        // 3: pop once from full, A5 accepted one cycle after ready returns
        chk("head_a1", 32'(rd_data), 32'hA1);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        chk("pop_count", 32'(count), 32'd3);
        cyc();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        exp_order[0] = 8'hA2; exp_order[1] = 8'hA3;
        exp_order[2] = 8'hA4; exp_order[3] = 8'hA5;
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(rd_data), 32'(exp_order[i]));
            cyc();
        end
        pop = 1'b0;
        chk("drained_empty", 32'(empty), 32'd1);

        // 4: steady stream with two entries resident, pointers wrap repeatedly
        in_valid = 1'b1;
        in_data  = 8'h00;
        cyc();
        in_data  = 8'h01;
        cyc();
        for (int i = 0; i < 20; i++) begin
            in_data = DW'(i + 2);
            pop     = 1'b1;
            cyc();
            chk("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        chk("stream_head", 32'(rd_data), 32'd20);
        cyc();
        cyc();
        pop = 1'b0;
        chk("stream_empty", 32'(empty), 32'd1);

        // 5: pop while empty, then a push with pop still high
        pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("underflow_count", 32'(count), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        cyc();
        in_valid = 1'b0;
        pop      = 1'b0;
        chk("push5a_empty", 32'(empty), 32'd0);
        chk("push5a_data", 32'(rd_data), 32'h5A);
        chk("push5a_count", 32'(count), 32'd1);
        pop = 1'b1;
        cyc();
        pop = 1'b0;

        // 6: data changed while stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'h30 + i);
            cyc();
        end
        in_data = 8'h11;
        cyc();
        chk("stall_no_err", 32'(proto_err), 32'd0);
        in_data = 8'h12;
        cyc();
        chk("perr_set", 32'(proto_err), 32'(PCHK));
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("perr_sticky", 32'(proto_err), 32'(PCHK));
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("perr_cleared", 32'(proto_err), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Randomized phase with protocol-compliant master and one mid-run reset
        for (int i = 0; i < 500; i++) begin
            int pp;
            pp = ((i / 60) % 2 == 0) ? 25 : 75;
            stalled = in_valid && !m_ready;
            if (i == 250) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                chk("mid_rst_ready", 32'(in_ready), 32'd0);
                chk("mid_rst_count", 32'(count), 32'd0);
                cyc();
                rst_n = 1'b1;
                stalled = 1'b0;
            end
            if (!stalled) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_data  = DW'($urandom);
            end
            pop = ($urandom_range(0, 99) < pp);
            cyc();
        end
        in_valid = 1'b0;
        pop      = 1'b0;
        cyc();
        cyc();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
